layer_controller: RTL and testbench

Sequencer and configuration block for the four-canvas compositing path. It owns the per-canvas visibility flags, which it updates only at frame boundaries so no frame tears, and the active-canvas selection. It forwards pen draw requests to the single selected canvas write port. It runs a clear engine that sweeps a whole canvas to COLOR_NONE, stalling pen traffic while the sweep runs. It sits between the user-input/command logic and the canvas frame memories; its visibility outputs drive the compositor's `canvasN_visible` inputs.

---
 rtl/common.sv | 29 ++
 rtl/addr_sweeper.sv | 34 +++
 rtl/layer_controller.sv | 151 +++++++++++++++
 tb/tb_layer_controller.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/common.sv
// Shared definitions for the canvas compositing path.
//   COLOR_WIDTH / COLOR_NONE : pixel format and the "transparent" clear value
//   COLOR_RED                : palette entry used by pen logic and benches
//   cmd_op_t                 : layer command opcodes
//   lc_state_t               : layer controller sequencer states
//   onehot4()                : canvas index to one-hot write-enable
package common;

  localparam int COLOR_WIDTH = 8;
  localparam logic [COLOR_WIDTH-1:0] COLOR_NONE = 8'h00;
  localparam logic [COLOR_WIDTH-1:0] COLOR_RED  = 8'hE0;

  typedef enum logic [1:0] {
    CMD_TOGGLE_VIS = 2'd0,
    CMD_SELECT     = 2'd1,
    CMD_CLEAR      = 2'd2,
    CMD_NOP        = 2'd3
  } cmd_op_t;

  typedef enum logic {
    IDLE     = 1'b0,
    CLEARING = 1'b1
  } lc_state_t;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/addr_sweeper.sv
// Linear address sweeper: counts 0 .. COUNT-1, one step per enabled cycle.
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : restart the sweep at address 0
//   enable       : advance one address this cycle
//   count        : address issued this cycle
//   done         : high in the cycle the last address (COUNT-1) is issued
// The count parks at COUNT-1 after the last address; it never wraps.
module addr_sweeper #(
  parameter int COUNT = 64,
  parameter int W     = $clog2(COUNT)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic         done
);

  localparam logic [W-1:0] LAST = W'(COUNT - 1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (start) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign done = enable && (count == LAST);

endmodule

// File: rtl/layer_controller.sv
// Layer controller for the four-canvas compositor.
//   frame_start          : vertical-blank pulse; shadow visibility goes live here
//   cmd_valid/ready/op/canvas : command channel
//   draw_req/ack/x/y/color    : pen write channel
//   canvas_we/wr_addr/wr_color: registered write port to the canvas memories
//   canvas_visible       : live visibility flags to the compositor
//   active_canvas        : canvas receiving pen writes
//   busy                 : clear sweep in progress
//   dbg_state            : sequencer state, for observation only
//
// Handshake: a command (pen request) transfers in a cycle where cmd_valid
// (draw_req) and cmd_ready (draw_ack) are both high on the rising edge. Both
// readies are high exactly when the sequencer is IDLE and do not depend on
// the valids; a command and a pen request may transfer in the same cycle.
module layer_controller
  import common::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int ADDR_W = $clog2(WIDTH*HEIGHT),
  // Sized from WIDTH+1 / HEIGHT+1 so an out-of-range coordinate is
  // representable even when the canvas dimension is a power of two.
  localparam int X_W   = $clog2(WIDTH+1),
  localparam int Y_W   = $clog2(HEIGHT+1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   frame_start,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  cmd_op_t                cmd_op,
  input  logic [1:0]             cmd_canvas,
  input  logic                   draw_req,
  output logic                   draw_ack,
  input  logic [X_W-1:0]         draw_x,
  input  logic [Y_W-1:0]         draw_y,
  input  logic [COLOR_WIDTH-1:0] draw_color,
  output logic [3:0]             canvas_we,
  output logic [ADDR_W-1:0]      canvas_wr_addr,
  output logic [COLOR_WIDTH-1:0] canvas_wr_color,
  output logic [3:0]             canvas_visible,
  output logic [1:0]             active_canvas,
  output logic                   busy,
  output lc_state_t              dbg_state
);

  localparam int N = WIDTH * HEIGHT;

  lc_state_t state_q, state_d;
  logic [3:0]  shadow_vis;
  logic [1:0]  clear_target;
  logic        cmd_fire, pen_fire, clear_start, pen_in_range;
  logic [ADDR_W-1:0] sweep_count;
  logic              sweep_done;
  logic [ADDR_W-1:0] pen_addr;

  logic [3:0]             we_d;
  logic [ADDR_W-1:0]      addr_d;
  logic [COLOR_WIDTH-1:0] color_d;

  assign cmd_ready   = (state_q == IDLE);
  assign draw_ack    = (state_q == IDLE);
  assign busy        = (state_q == CLEARING);
  assign dbg_state   = state_q;
  assign cmd_fire    = cmd_valid && cmd_ready;
  assign pen_fire    = draw_req && draw_ack;
  assign clear_start = cmd_fire && (cmd_op == CMD_CLEAR);

  assign pen_in_range = (draw_x < X_W'(WIDTH)) && (draw_y < Y_W'(HEIGHT));
  assign pen_addr     = ADDR_W'(draw_y) * ADDR_W'(WIDTH) + ADDR_W'(draw_x);

  addr_sweeper #(
    .COUNT (N),
    .W     (ADDR_W)
  ) u_sweeper (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (clear_start),
    .enable  (state_q == CLEARING),
    .count   (sweep_count),
    .done    (sweep_done)
  );

  // Sequencer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (clear_start) state_d = CLEARING;
      CLEARING: if (sweep_done)  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Command decode and visibility. canvas_visible samples the shadow value
  // from before any toggle in the same cycle, so a coincident toggle waits
  // for the following frame_start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_vis     <= 4'b1111;
      canvas_visible <= 4'b1111;
      active_canvas  <= 2'd0;
      clear_target   <= 2'd0;
    end else begin
      if (frame_start) canvas_visible <= shadow_vis;
      if (cmd_fire) begin
        case (cmd_op)
          CMD_TOGGLE_VIS: shadow_vis[cmd_canvas] <= ~shadow_vis[cmd_canvas];
          CMD_SELECT:     active_canvas <= cmd_canvas;
          CMD_CLEAR:      clear_target  <= cmd_canvas;
          default:        ;
        endcase
      end
    end
  end

  // Write mux. Pen traffic is only acked in IDLE, so pen and clear writes
  // never compete; a pen write accepted alongside CMD_CLEAR lands one cycle
  // before the first clear write. Address/colour hold when no write issues.
  always_comb begin
    we_d    = 4'b0000;
    addr_d  = canvas_wr_addr;
    color_d = canvas_wr_color;
    if (state_q == CLEARING) begin
      we_d    = onehot4(clear_target);
      addr_d  = sweep_count;
      color_d = COLOR_NONE;
    end else if (pen_fire && pen_in_range) begin
      we_d    = onehot4(active_canvas);
      addr_d  = pen_addr;
      color_d = draw_color;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      canvas_we       <= 4'b0000;
      canvas_wr_addr  <= '0;
      canvas_wr_color <= '0;
    end else begin
      canvas_we       <= we_d;
      canvas_wr_addr  <= addr_d;
      canvas_wr_color <= color_d;
    end
  end

endmodule

// File: tb/tb_layer_controller.sv
module tb_layer_controller;
  import common::*;

  localparam int WIDTH  = 8;
  localparam int HEIGHT = 8;
  localparam int N      = WIDTH * HEIGHT;
  localparam int ADDR_W = 6;
  localparam int WR_W   = 4 + ADDR_W + COLOR_WIDTH;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic                   frame_start;
  logic                   cmd_valid;
  logic                   cmd_ready;
  cmd_op_t                cmd_op;
  logic [1:0]             cmd_canvas;
  logic                   draw_req;
  logic                   draw_ack;
  logic [3:0]             draw_x;
  logic [3:0]             draw_y;
  logic [COLOR_WIDTH-1:0] draw_color;
  logic [3:0]             canvas_we;
  logic [ADDR_W-1:0]      canvas_wr_addr;
  logic [COLOR_WIDTH-1:0] canvas_wr_color;
  logic [3:0]             canvas_visible;
  logic [1:0]             active_canvas;
  logic                   busy;
  lc_state_t              dbg_state;

  int checks = 0;
  int errors = 0;
  logic [WR_W-1:0] exp_q[$];

  layer_controller #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .frame_start     (frame_start),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .cmd_canvas      (cmd_canvas),
    .draw_req        (draw_req),
    .draw_ack        (draw_ack),
    .draw_x          (draw_x),
    .draw_y          (draw_y),
    .draw_color      (draw_color),
    .canvas_we       (canvas_we),
    .canvas_wr_addr  (canvas_wr_addr),
    .canvas_wr_color (canvas_wr_color),
    .canvas_visible  (canvas_visible),
    .active_canvas   (active_canvas),
    .busy            (busy),
    .dbg_state       (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [3:0] we, input int addr, input logic [COLOR_WIDTH-1:0] color);
    exp_q.push_back({we, ADDR_W'(addr), color});
  endtask

  // Offer a command for one cycle; it must be accepted.
  task automatic do_cmd(input cmd_op_t op, input logic [1:0] idx);
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_canvas = idx;
    @(negedge clk);
    check("cmd_ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    cmd_op    = CMD_NOP;
  endtask

  task automatic do_pen(input int x, input int y, input logic [COLOR_WIDTH-1:0] color);
    draw_req   = 1'b1;
    draw_x     = 4'(x);
    draw_y     = 4'(y);
    draw_color = color;
    @(negedge clk);
    check("draw_ack", 32'(draw_ack), 32'd1);
    tick();
    draw_req = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // scoreboard: every write the DUT issues must be the next expected one
  initial begin
    forever begin
      @(negedge clk);
      if (canvas_we != 4'b0000) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {14'd0, canvas_we, canvas_wr_addr, canvas_wr_color}, 32'd0);
        end else begin
          check("write", 32'({canvas_we, canvas_wr_addr, canvas_wr_color}), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    int cnt;
    reset_n     = 1'b0;
    frame_start = 1'b0;
    cmd_valid   = 1'b0;
    cmd_op      = CMD_NOP;
    cmd_canvas  = 2'd0;
    draw_req    = 1'b0;
    draw_x      = 4'd0;
    draw_y      = 4'd0;
    draw_color  = '0;

    // reset state
    idle_cycles(3);
    @(negedge clk);
    check("rst_visible", 32'(canvas_visible), 32'hF);
    check("rst_active", 32'(active_canvas), 32'd0);
    check("rst_we", 32'(canvas_we), 32'd0);
    check("rst_addr", 32'(canvas_wr_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    tick();
    reset_n = 1'b1;
    idle_cycles(2);

    // select + pen
    do_cmd(CMD_SELECT, 2'd2);
    check("active_after_select", 32'(active_canvas), 32'd2);
    push_wr(4'b0100, 43, COLOR_RED);
    do_pen(3, 5, COLOR_RED);
    idle_cycles(2);
    do_pen(9, 0, 8'h55);   // out of range: acked, no write
    do_pen(0, 8, 8'h56);
    push_wr(4'b0100, 63, 8'h77);
    do_pen(7, 7, 8'h77);
    idle_cycles(2);
    check("q_empty_pen", 32'(exp_q.size()), 32'd0);

    // visibility toggling
    do_cmd(CMD_TOGGLE_VIS, 2'd1);
    idle_cycles(2);
    check("vis_before_frame", 32'(canvas_visible), 32'hF);
    pulse_frame();
    check("vis_after_frame", 32'(canvas_visible), 32'hD);
    frame_start = 1'b1;
    do_cmd(CMD_TOGGLE_VIS, 2'd1);
    frame_start = 1'b0;
    check("vis_coincident", 32'(canvas_visible), 32'hD);
    idle_cycles(2);
    pulse_frame();
    check("vis_next_frame", 32'(canvas_visible), 32'hF);

    // clear canvas 3 with pen held during sweep
    for (int i = 0; i < N; i++) push_wr(4'b1000, i, COLOR_NONE);
    push_wr(4'b0100, 9, 8'h33);
    do_cmd(CMD_CLEAR, 2'd3);
    draw_req   = 1'b1;
    draw_x     = 4'd1;
    draw_y     = 4'd1;
    draw_color = 8'h33;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
      check("ack_low_in_sweep", 32'(draw_ack), 32'd0);
      if (cnt == 10) check("dbg_state_clearing", 32'(dbg_state), 32'(CLEARING));
    end
    check("busy_cycles", 32'(cnt), 32'(N));
    check("ack_after_sweep", 32'(draw_ack), 32'd1);
    tick();
    draw_req = 1'b0;
    idle_cycles(3);
    check("q_empty_clear3", 32'(exp_q.size()), 32'd0);

    // clear canvas 0 with a pen request in the same cycle
    push_wr(4'b0100, 10, 8'h1C);
    for (int i = 0; i < N; i++) push_wr(4'b0001, i, COLOR_NONE);
    cmd_valid  = 1'b1;
    cmd_op     = CMD_CLEAR;
    cmd_canvas = 2'd0;
    draw_req   = 1'b1;
    draw_x     = 4'd2;
    draw_y     = 4'd1;
    draw_color = 8'h1C;
    @(negedge clk);
    check("both_ready_cmd", 32'(cmd_ready), 32'd1);
    check("both_ready_pen", 32'(draw_ack), 32'd1);
    tick();
    cmd_valid = 1'b0;
    cmd_op    = CMD_NOP;
    draw_req  = 1'b0;
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
    end
    check("busy_cycles_c0", 32'(cnt), 32'(N));
    idle_cycles(3);
    check("q_empty_clear0", 32'(exp_q.size()), 32'd0);

    // reset in the middle of a sweep
    for (int i = 0; i <= 20; i++) push_wr(4'b1000, i, COLOR_NONE);
    do_cmd(CMD_CLEAR, 2'd3);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (canvas_we != 4'b0000 && canvas_wr_addr == ADDR_W'(20)) break;
      cnt++;
    end
    check("reached_addr20", 32'(cnt < 100), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_we_drop", 32'(canvas_we), 32'd0);
    check("async_busy_drop", 32'(busy), 32'd0);
    idle_cycles(2);
    reset_n = 1'b1;
    idle_cycles(10);
    check("q_empty_reset", 32'(exp_q.size()), 32'd0);
    check("post_rst_visible", 32'(canvas_visible), 32'hF);
    check("post_rst_active", 32'(active_canvas), 32'd0);
    check("post_rst_ready", 32'(cmd_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
